// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the shared slave.
// The o_m*_err signals exist only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              i_m0_req;
    logic              i_m0_we;
    logic [ADDR_W-1:0] i_m0_addr;
    logic [DATA_W-1:0] i_m0_wdata;
    logic [3:0]        i_m0_be;
    logic              o_m0_ack;
    logic [DATA_W-1:0] o_m0_rdata;

    logic              i_m1_req;
    logic              i_m1_we;
    logic [ADDR_W-1:0] i_m1_addr;
    logic [DATA_W-1:0] i_m1_wdata;
    logic [3:0]        i_m1_be;
    logic              o_m1_ack;
    logic [DATA_W-1:0] o_m1_rdata;

    logic              o_s_req;
    logic              o_s_we;
    logic [ADDR_W-1:0] o_s_addr;
    logic [DATA_W-1:0] o_s_wdata;
    logic [3:0]        o_s_be;
    logic              i_s_ack;
    logic [DATA_W-1:0] i_s_rdata;

    logic              o_owner;
    logic              o_busy;

`ifdef MEM_ARB_TIMEOUT_EN
    logic              o_m0_err;
    logic              o_m1_err;
`endif

    // Arbiter view: serves the masters and drives the slave.
    modport slave (
`ifdef MEM_ARB_TIMEOUT_EN
        output o_m0_err, output o_m1_err,
`endif
        input  i_m0_req, input i_m0_we, input i_m0_addr, input i_m0_wdata, input i_m0_be,
        output o_m0_ack, output o_m0_rdata,
        input  i_m1_req, input i_m1_we, input i_m1_addr, input i_m1_wdata, input i_m1_be,
        output o_m1_ack, output o_m1_rdata,
        output o_s_req, output o_s_we, output o_s_addr, output o_s_wdata, output o_s_be,
        input  i_s_ack, input i_s_rdata,
        output o_owner, output o_busy
    );

    // Environment view: the masters and the slave model around the arbiter.
    modport master (
`ifdef MEM_ARB_TIMEOUT_EN
        input  o_m0_err, input o_m1_err,
`endif
        output i_m0_req, output i_m0_we, output i_m0_addr, output i_m0_wdata, output i_m0_be,
        input  o_m0_ack, input o_m0_rdata,
        output i_m1_req, output i_m1_we, output i_m1_addr, output i_m1_wdata, output i_m1_be,
        input  o_m1_ack, input o_m1_rdata,
        input  o_s_req, input o_s_we, input o_s_addr, input o_s_wdata, input o_s_be,
        output i_s_ack, output i_s_rdata,
        input  o_owner, input o_busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave memory bus arbiter: fixed master-0 priority, bounded master-1 starvation.
// Defining MEM_ARB_TIMEOUT_EN adds a slave-ack timeout with per-master error flags.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned STARVE_MAX  = 8
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
    input logic              i_clk,
    input logic              i_reset,
    mem_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1
    } state_e;

    localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [7:0]        starve_cnt_q, starve_cnt_d;
    logic              owner_q, owner_d;
    logic              s_req_q, s_req_d;
    logic              s_we_q, s_we_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic [3:0]        s_be_q, s_be_d;

    logic              grant_m0;
    logic              grant_m1;
    logic              in_gnt;
    logic              done;
    logic              timeout;
    logic [DATA_W-1:0] rsp_data;

    // Arbitration only in IDLE; on a tie m1 wins once m0 has used up its allowed streak.
    assign grant_m1 = (state_q == StIdle) && bus.i_m1_req &&
                      (!bus.i_m0_req || (starve_cnt_q == StarveMax));
    assign grant_m0 = (state_q == StIdle) && bus.i_m0_req && !grant_m1;
    assign in_gnt   = (state_q == StGnt0) || (state_q == StGnt1);
    assign done     = in_gnt && (bus.i_s_ack || timeout);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;

    assign timeout = in_gnt && !bus.i_s_ack && (wait_cnt_q == WaitLast);

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (grant_m0 || grant_m1) begin
            wait_cnt_d = '0;
        end else if (in_gnt && !bus.i_s_ack) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.o_m0_err = (state_q == StGnt0) && timeout;
    assign bus.o_m1_err = (state_q == StGnt1) && timeout;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        s_req_d   = s_req_q;
        s_we_d    = s_we_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        s_be_d    = s_be_q;
        unique case (state_q)
            StIdle: begin
                if (grant_m0 || grant_m1) begin
                    state_d   = grant_m1 ? StGnt1 : StGnt0;
                    owner_d   = grant_m1;
                    s_req_d   = 1'b1;
                    s_we_d    = grant_m1 ? bus.i_m1_we    : bus.i_m0_we;
                    s_addr_d  = grant_m1 ? bus.i_m1_addr  : bus.i_m0_addr;
                    s_wdata_d = grant_m1 ? bus.i_m1_wdata : bus.i_m0_wdata;
                    s_be_d    = grant_m1 ? bus.i_m1_be    : bus.i_m0_be;
                end
            end
            StGnt0, StGnt1: begin
                // Going back through IDLE guarantees one free cycle between slave requests.
                if (done) begin
                    state_d = StIdle;
                    s_req_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                s_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.i_m1_req || grant_m1) begin
            starve_cnt_d = '0;
        end else if (grant_m0 && (starve_cnt_q < StarveMax)) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            owner_q      <= 1'b0;
            s_req_q      <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_be_q       <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
            s_req_q      <= s_req_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_be_q       <= s_be_d;
        end
    end

    assign rsp_data = timeout ? DATA_W'(32'hDEAD_BEEF) : bus.i_s_rdata;

    assign bus.o_s_req    = s_req_q;
    assign bus.o_s_we     = s_we_q;
    assign bus.o_s_addr   = s_addr_q;
    assign bus.o_s_wdata  = s_wdata_q;
    assign bus.o_s_be     = s_be_q;
    assign bus.o_owner    = owner_q;
    assign bus.o_busy     = s_req_q;

    assign bus.o_m0_ack   = (state_q == StGnt0) && (bus.i_s_ack || timeout);
    assign bus.o_m1_ack   = (state_q == StGnt1) && (bus.i_s_ack || timeout);
    assign bus.o_m0_rdata = (state_q == StGnt0) ? rsp_data : '0;
    assign bus.o_m1_rdata = (state_q == StGnt1) ? rsp_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model. The timeout scenario runs only with MEM_ARB_TIMEOUT_EN.
module tb_mem_bus_arbiter;

    localparam int unsigned StarveMax  = 3;
    localparam int unsigned TimeoutCyc = 16;

    logic clk   = 1'b0;
    logic rst_v = 1'b1;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_TIMEOUT_EN
    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(StarveMax), .TIMEOUT_CYC(TimeoutCyc)
    ) dut (.i_clk(clk), .i_reset(rst_v), .bus(bus));
`else
    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(StarveMax)
    ) dut (.i_clk(clk), .i_reset(rst_v), .bus(bus));
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Master agents
    logic        req_v[2]   = '{1'b0, 1'b0};
    logic        we_v[2]    = '{1'b0, 1'b0};
    logic [31:0] addr_v[2]  = '{32'h0, 32'h0};
    logic [31:0] wdata_v[2] = '{32'h0, 32'h0};
    logic [3:0]  be_v[2]    = '{4'h0, 4'h0};
    bit          want[2]    = '{1'b0, 1'b0};
    bit          drop[2]    = '{1'b0, 1'b0};
    bit          rand_fields = 1'b0;

    // Slave agent
    int          lat_cfg    = 0;
    bit          stall      = 1'b0;
    bit          force_ack  = 1'b0;
    bit          spurious   = 1'b0;
    bit          fix_rdata  = 1'b0;
    logic [31:0] rdata_fix  = 32'h0;
    logic        s_ack_v    = 1'b0;
    logic [31:0] s_rdata_v  = 32'h0;

    // Reference model: one outstanding transaction, plus a log of m0 grant cycles
    bit          m_busy, m_owner, m_clean, last_to;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    int          m_age, m_lat;
    int          cyc = 0;
    int          m1_wait_start = 0;
    int          grant_q[$];

    bit exp_order[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_fields(input int m);
        we_v[m]    = 1'($urandom_range(1));
        addr_v[m]  = $urandom;
        wdata_v[m] = $urandom;
        be_v[m]    = 4'($urandom);
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 1'b0;
        m_clean = 1'b1;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        m_age   = 0;
        grant_q.delete();
    endtask

    // m0 wins granted since m1's current request began, capped at the limit
    function automatic int starve_now();
        int n = 0;
        foreach (grant_q[i]) if (grant_q[i] >= m1_wait_start) n++;
        return (n > int'(StarveMax)) ? int'(StarveMax) : n;
    endfunction

    task automatic apply_inputs();
        bus.i_m0_req   = req_v[0];
        bus.i_m0_we    = we_v[0];
        bus.i_m0_addr  = addr_v[0];
        bus.i_m0_wdata = wdata_v[0];
        bus.i_m0_be    = be_v[0];
        bus.i_m1_req   = req_v[1];
        bus.i_m1_we    = we_v[1];
        bus.i_m1_addr  = addr_v[1];
        bus.i_m1_wdata = wdata_v[1];
        bus.i_m1_be    = be_v[1];
        bus.i_s_ack    = s_ack_v;
        bus.i_s_rdata  = s_rdata_v;
    endtask

    task automatic drive_and_check();
        logic [31:0] exp_rd;
        for (int m = 0; m < 2; m++) begin
            if (!req_v[m] && want[m]) begin
                req_v[m] = 1'b1;
                if (m == 1) m1_wait_start = cyc;
                if (rand_fields) new_fields(m);
            end else if (rand_fields && (!req_v[m] || (m_busy && m_owner == m))) begin
                new_fields(m);  // idle or already latched: arbiter must ignore these
            end
        end
        s_rdata_v = fix_rdata ? rdata_fix : $urandom;
        s_ack_v   = force_ack || (m_busy && !stall && !rst_v && m_age >= m_lat) ||
                    (!m_busy && spurious && ($urandom_range(3) == 0));
        apply_inputs();
        #1;
        last_to = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        last_to = m_busy && !s_ack_v && (m_age == int'(TimeoutCyc) - 1);
`endif
        exp_rd = last_to ? 32'hDEAD_BEEF : s_rdata_v;
        chk("s_req", bus.o_s_req, m_busy);
        chk("busy", bus.o_busy, m_busy);
        chk("owner", bus.o_owner, m_owner);
        if (m_busy || m_clean) begin
            chk("s_we", bus.o_s_we, m_we);
            chk("s_addr", bus.o_s_addr, m_addr);
            chk("s_wdata", bus.o_s_wdata, m_wdata);
            chk("s_be", bus.o_s_be, m_be);
        end
        chk("m0_ack", bus.o_m0_ack, m_busy && !m_owner && (s_ack_v || last_to));
        chk("m1_ack", bus.o_m1_ack, m_busy && m_owner && (s_ack_v || last_to));
        chk("m0_rdata", bus.o_m0_rdata, (m_busy && !m_owner) ? exp_rd : 32'h0);
        chk("m1_rdata", bus.o_m1_rdata, (m_busy && m_owner) ? exp_rd : 32'h0);
`ifdef MEM_ARB_TIMEOUT_EN
        chk("m0_err", bus.o_m0_err, m_busy && !m_owner && last_to);
        chk("m1_err", bus.o_m1_err, m_busy && m_owner && last_to);
`endif
    endtask

    task automatic advance();
        bit win;
        if (rst_v) begin
            model_reset();
        end else if (m_busy) begin
            if (s_ack_v || last_to) begin
                m_busy = 1'b0;
                drop[m_owner] = 1'b1;
            end else begin
                m_age++;
            end
        end else if (req_v[0] || req_v[1]) begin
            win = req_v[1] && (!req_v[0] || starve_now() >= int'(StarveMax));
            if (!win) grant_q.push_back(cyc);
            m_busy  = 1'b1;
            m_owner = win;
            m_clean = 1'b0;
            m_we    = we_v[win];
            m_addr  = addr_v[win];
            m_wdata = wdata_v[win];
            m_be    = be_v[win];
            m_age   = 0;
            m_lat   = (lat_cfg < 0) ? int'($urandom_range(3)) : lat_cfg;
        end
        @(posedge clk);
        #2;
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (drop[m]) begin
                req_v[m] = 1'b0;
                drop[m]  = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        want[0] = 1'b0;
        want[1] = 1'b0;
        while ((m_busy || req_v[0] || req_v[1]) && n < 60) begin
            drive_and_check();
            advance();
            n++;
        end
        chk("drain_bound", {m_busy, req_v[0], req_v[1]}, 3'b000);
    endtask

    initial begin
        // Reset and reset-state checks
        apply_inputs();
        repeat (3) @(posedge clk);
        #2;
        rst_v = 1'b0;
        model_reset();
        drive_and_check();
        advance();

        // m0 read alone, slave answers 2 cycles after o_s_req
        lat_cfg = 2; fix_rdata = 1'b1; rdata_fix = 32'h1234_5678;
        we_v[0] = 1'b0; addr_v[0] = 32'h0000_2000; wdata_v[0] = 32'h0; be_v[0] = 4'hF;
        want[0] = 1'b1;
        drive_and_check(); chk("t1_req_at_t", bus.o_s_req, 1'b0); advance();
        drive_and_check(); chk("t1_req_at_t1", bus.o_s_req, 1'b1);
        chk("t1_addr", bus.o_s_addr, 32'h0000_2000); advance();
        drive_and_check(); chk("t1_no_ack_yet", bus.o_m0_ack, 1'b0); advance();
        want[0] = 1'b0;
        drive_and_check(); chk("t1_ack", bus.o_m0_ack, 1'b1);
        chk("t1_rdata", bus.o_m0_rdata, 32'h1234_5678);
        chk("t1_m1_ack", bus.o_m1_ack, 1'b0); advance();
        drive_and_check(); chk("t1_idle", bus.o_busy, 1'b0); advance();

        // Both request together: m0 first, m1 after one IDLE cycle
        lat_cfg = 1; fix_rdata = 1'b0;
        we_v[0] = 1'b0; addr_v[0] = 32'h0000_3000; wdata_v[0] = 32'h0; be_v[0] = 4'hF;
        we_v[1] = 1'b1; addr_v[1] = 32'h0000_7000; wdata_v[1] = 32'hA5A5_A5A5; be_v[1] = 4'hF;
        want[0] = 1'b1; want[1] = 1'b1;
        drive_and_check(); advance();
        want[0] = 1'b0;
        drive_and_check(); chk("t2_owner0", bus.o_owner, 1'b0);
        chk("t2_req0", bus.o_s_req, 1'b1); advance();
        drive_and_check(); chk("t2_m0_ack", bus.o_m0_ack, 1'b1); advance();
        drive_and_check(); chk("t2_gap", bus.o_s_req, 1'b0); advance();
        want[1] = 1'b0;
        drive_and_check(); chk("t2_owner1", bus.o_owner, 1'b1);
        chk("t2_we", bus.o_s_we, 1'b1); chk("t2_addr", bus.o_s_addr, 32'h0000_7000);
        chk("t2_wdata", bus.o_s_wdata, 32'hA5A5_A5A5); chk("t2_be", bus.o_s_be, 4'hF);
        advance();
        drive_and_check(); chk("t2_m1_ack", bus.o_m1_ack, 1'b1); advance();
        drive_and_check(); advance();

        // Continuous contention, ack latency 1: one grant every 3 cycles
        rand_fields = 1'b1; lat_cfg = 1; want[0] = 1'b1; want[1] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            drive_and_check();
            if (k % 3 == 1) chk($sformatf("t3_order%0d", k / 3), bus.o_owner, exp_order[k / 3]);
            advance();
        end
        drain();

        // m1 write alone with partial byte enables
        rand_fields = 1'b0; lat_cfg = 3;
        we_v[1] = 1'b1; addr_v[1] = 32'h0000_4400; wdata_v[1] = 32'h0BAD_F00D; be_v[1] = 4'b0011;
        want[1] = 1'b1;
        drive_and_check(); chk("t4_busy_pre", bus.o_busy, 1'b0); advance();
        want[1] = 1'b0;
        drive_and_check(); chk("t4_be", bus.o_s_be, 4'b0011); chk("t4_we", bus.o_s_we, 1'b1);
        chk("t4_busy_gnt", bus.o_busy, 1'b1); advance();
        drive_and_check(); advance();
        drive_and_check(); advance();
        drive_and_check(); chk("t4_m1_ack", bus.o_m1_ack, 1'b1);
        chk("t4_busy_ack", bus.o_busy, 1'b1); advance();
        drive_and_check(); chk("t4_busy_post", bus.o_busy, 1'b0); advance();

        // Reset during the third m0 grant, when the starvation limit has been reached
        rand_fields = 1'b1; lat_cfg = 1; want[0] = 1'b1; want[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            drive_and_check();
            advance();
        end
        rst_v = 1'b1;
        drive_and_check(); chk("t5_gnt_before_rst", bus.o_s_req, 1'b1); advance();
        rst_v = 1'b0; force_ack = 1'b1;
        drive_and_check(); chk("t5_req_dropped", bus.o_s_req, 1'b0);
        chk("t5_busy", bus.o_busy, 1'b0); chk("t5_owner", bus.o_owner, 1'b0);
        chk("t5_late_ack", bus.o_m0_ack, 1'b0); advance();
        force_ack = 1'b0;
        drive_and_check(); chk("t5_starve_cleared", bus.o_owner, 1'b0); advance();
        drain();

        // Random traffic against the model, with stray slave acks while idle
        rand_fields = 1'b1; lat_cfg = -1; spurious = 1'b1;
        for (int k = 0; k < 600; k++) begin
            want[0] = ($urandom_range(3) != 0);
            want[1] = ($urandom_range(2) != 0);
            drive_and_check();
            advance();
        end
        spurious = 1'b0;
        drain();

`ifdef MEM_ARB_TIMEOUT_EN
        // Slave never answers: m0 times out, then the waiting m1 is served
        stall = 1'b1; lat_cfg = 0; want[0] = 1'b1; want[1] = 1'b1;
        drive_and_check(); advance();
        want[0] = 1'b0;
        for (int k = 0; k < int'(TimeoutCyc); k++) begin
            drive_and_check();
            if (k == int'(TimeoutCyc) - 1) begin
                chk("t6_to_ack", bus.o_m0_ack, 1'b1);
                chk("t6_to_err", bus.o_m0_err, 1'b1);
                chk("t6_to_rdata", bus.o_m0_rdata, 32'hDEAD_BEEF);
            end else begin
                chk("t6_no_err", bus.o_m0_err, 1'b0);
            end
            advance();
        end
        stall = 1'b0; want[1] = 1'b0;
        drive_and_check(); chk("t6_idle", bus.o_s_req, 1'b0); advance();
        drive_and_check(); chk("t6_m1_served", bus.o_owner, 1'b1);
        chk("t6_m1_req", bus.o_s_req, 1'b1); advance();
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
